// File: rtl/port_hex_uart_pkg.sv
// Shared constants, FSM state type and nibble-to-ASCII helper for port_hex_uart.
package port_hex_uart_pkg;

    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_0          = 8'h30;
    localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (ASCII_0 + {4'd0, n}) : (ASCII_A_MINUS_10 + {4'd0, n});
    endfunction

endpackage

// File: rtl/port_hex_uart_tx.sv
// 8N1 UART transmitter: one character per start pulse, idle-high line.
// done is high during the final cycle of the stop bit, so the consumer can
// react on the same edge the stop bit completes.
module port_hex_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic          r_active;
    logic          r_txd;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;   // bits still to send after the current one
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));

    // Bit-period counter and shift register; start is only honoured while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_txd    <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= 4'd0;
            r_shift  <= '1;
        end else if (!r_active) begin
            if (start) begin
                r_active <= 1'b1;
                r_txd    <= 1'b0;
                r_cnt    <= '0;
                r_bit    <= 4'd0;
                r_shift  <= {1'b1, data};
            end
        end else if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 4'd9) begin
                r_active <= 1'b0;
                r_txd    <= 1'b1;
            end else begin
                r_bit   <= r_bit + 4'd1;
                r_txd   <= r_shift[0];
                r_shift <= {1'b1, r_shift[8:1]};
            end
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign txd  = r_txd;
    assign done = r_active && (r_bit == 4'd9) && w_bit_end;

endmodule

// File: rtl/port_hex_uart.sv
// Watches a monitored word and prints every new value over UART as
// DATA_WIDTH/4 uppercase hex digits followed by CR LF.
module port_hex_uart
    import port_hex_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] port_in,
    output logic                  uart_txd,
    output logic                  busy,
    output logic [7:0]            drop_count
);

    localparam int DIGITS = DATA_WIDTH / 4;
    localparam int NCHARS = DIGITS + 2;
    localparam int IW     = $clog2(NCHARS);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_hold;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_snap;
    logic [DATA_WIDTH-1:0] r_last;
    logic [DATA_WIDTH-1:0] r_prev;
    logic [7:0]            r_drop;

    logic [3:0] w_nib;
    logic [7:0] w_char;
    logic       w_start;
    logic       w_done;
    logic       w_txd;
    logic       w_last;
    logic       w_frame_end;

    assign w_last      = (r_idx == IW'(NCHARS - 1));
    assign w_frame_end = (r_state == ST_SEND) && w_done && w_last;
    // The first character waits one LOAD cycle so its start bit lands two
    // edges after the change; later characters pay only the one-cycle bubble.
    assign w_start     = (r_state == ST_LOAD) && !r_hold;

    // Character select: hex digits MSB first, then CR, then LF.
    always_comb begin
        w_nib  = 4'd0;
        w_char = ASCII_LF;
        for (int d = 0; d < DIGITS; d++) begin
            if (int'(r_idx) == d) w_nib = r_snap[DATA_WIDTH-1-4*d -: 4];
        end
        if (int'(r_idx) < DIGITS)       w_char = nib2ascii(w_nib);
        else if (int'(r_idx) == DIGITS) w_char = ASCII_CR;
    end

    // Change detection, frame sequencing and the saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_hold  <= 1'b0;
            r_idx   <= '0;
            r_snap  <= '0;
            r_last  <= '0;
            r_prev  <= '0;
            r_drop  <= 8'd0;
        end else begin
            r_prev <= port_in;
            // A change on the edge the frame ends is left for IDLE to pick up.
            if (r_busy && !w_frame_end && (port_in != r_prev) && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
            case (r_state)
                ST_IDLE: begin
                    if (port_in != r_last) begin
                        r_snap  <= port_in;
                        r_last  <= port_in;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_hold  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (r_hold) r_hold  <= 1'b0;
                    else        r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_done) begin
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    port_hex_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .data  (w_char),
        .txd   (w_txd),
        .done  (w_done)
    );

    assign uart_txd   = w_txd;
    assign busy       = r_busy;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_port_hex_uart.sv
// Directed + randomized bench for port_hex_uart with a serial receiver and a
// string-based model of the expected frame text.
module tb_port_hex_uart;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] port_in;
    logic        uart_txd;
    logic        busy;
    logic [7:0]  drop_count;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [7:0]  rxq[$];

    always #5 clk = ~clk;

    port_hex_uart #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .port_in    (port_in),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .drop_count (drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Expected character i of the frame for value v.
    function automatic logic [7:0] model_char(input logic [31:0] v, input int i);
        string s;
        s = $sformatf("%08h", v);
        s = s.toupper();
        if (i < 8) return s[i];
        return (i == 8) ? 8'h0D : 8'h0A;
    endfunction

    task automatic check_frame(input string tag, input logic [31:0] v);
        logic [7:0] g;
        chk({tag, "_len"}, rxq.size(), 10);
        for (int i = 0; i < 10; i++) begin
            g = 8'hxx;
            if (i < rxq.size()) g = rxq[i];
            chk($sformatf("%s_c%0d", tag, i), {24'h0, g}, {24'h0, model_char(v, i)});
        end
        rxq.delete();
    endtask

    task automatic wait_busy(input string tag, input logic lvl, input int budget);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, lvl);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy !== 1'b0 || uart_txd !== 1'b1) bad++;
        end
        chk(tag, bad, 0);
    endtask

    // Serial receiver sampling mid-bit.
    initial begin : rx
        logic [7:0] d;
        logic       sb, sp;
        forever begin
            @(negedge uart_txd);
            if (reset !== 1'b0) continue;
            repeat (2) @(posedge clk);
            #1 sb = uart_txd;
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(posedge clk);
                #1 d[b] = uart_txd;
            end
            repeat (CPB) @(posedge clk);
            #1 sp = uart_txd;
            if (sb == 1'b0 && sp == 1'b1) rxq.push_back(d);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          k, t1, t2, t3, bad, errs, exp_drop;
        logic [31:0] v;
        logic [9:0]  fr;

        reset    = 1'b1;
        port_in  = 32'h0;
        exp_drop = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and a quiet line with port_in held at 0
        @(negedge clk);
        chk("rst_txd", uart_txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop_count, 8'd0);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || busy !== 1'b0 || drop_count !== 8'd0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // 0 -> A5: latency, frame length, and three dropped changes mid-frame
        @(negedge clk) port_in = 32'h0000_00A5;
        @(negedge clk);
        chk("a5_busy_rise", busy, 1'b1);
        chk("a5_txd_n0", uart_txd, 1'b1);
        @(negedge clk) chk("a5_txd_n1", uart_txd, 1'b1);
        @(negedge clk) chk("a5_txd_n2", uart_txd, 1'b0);
        t1 = $urandom_range(10, 120);
        t2 = $urandom_range(130, 250);
        t3 = $urandom_range(260, 380);
        k  = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == t1) begin port_in = 32'hA6; exp_drop++; end
            if (k == t2) begin port_in = 32'hA5; exp_drop++; end
            if (k == t3) begin port_in = 32'hA7; exp_drop++; end
        end while (busy === 1'b1 && k < 2000);
        chk("a5_busy_fall", k, 409);
        chk("drop_3", drop_count, exp_drop);
        check_frame("f_a5", 32'hA5);
        wait_busy("a7_rise", 1'b1, 10);
        wait_busy("a7_fall", 1'b0, 1000);
        check_frame("f_a7", 32'hA7);
        quiet("a7_only_once", 60);
        chk("a7_no_extra", rxq.size(), 0);

        // DEADBEEF: bit-level check of 'D' and the one-cycle bubble
        v = 32'hDEAD_BEEF;
        @(negedge clk) port_in = v;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        fr   = {1'b1, model_char(v, 0), 1'b0};
        errs = 0;
        for (int j = 0; j < 10 * CPB; j++) begin
            if (j > 0) @(negedge clk);
            if (uart_txd !== fr[j / CPB]) errs++;
        end
        chk("d_bits", errs, 0);
        @(negedge clk) chk("bubble", uart_txd, 1'b1);
        @(negedge clk) chk("char1_start", uart_txd, 1'b0);
        wait_busy("dead_fall", 1'b0, 1000);
        check_frame("f_dead", v);

        // Reset in the middle of the third character
        v = $urandom | 32'h1;
        if (v == 32'hDEAD_BEEF) v = v ^ 32'h2;
        @(negedge clk) port_in = v;
        repeat (95) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_txd", uart_txd, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_drop", drop_count, 8'd0);
        port_in  = 32'h0;
        reset    = 1'b0;
        exp_drop = 0;
        quiet("last_value_cleared", 60);
        rxq.delete();
        @(negedge clk) port_in = 32'h1;
        wait_busy("one_rise", 1'b1, 10);
        wait_busy("one_fall", 1'b0, 1000);
        check_frame("f_one", 32'h1);

        // Random values
        for (int r = 0; r < 3; r++) begin
            v = $urandom;
            if (v == port_in) v = ~v;
            @(negedge clk) port_in = v;
            wait_busy($sformatf("rnd%0d_rise", r), 1'b1, 10);
            wait_busy($sformatf("rnd%0d_fall", r), 1'b0, 1000);
            check_frame($sformatf("f_rnd%0d", r), v);
            chk($sformatf("rnd%0d_drop", r), drop_count, exp_drop);
        end

        // 300 toggles inside one frame: drop counter saturates
        v = $urandom;
        if (v == port_in || (v ^ 32'h1) == port_in) v = ~port_in;
        @(negedge clk) port_in = v;
        @(negedge clk);
        chk("sat_busy", busy, 1'b1);
        for (int t = 0; t < 300; t++) begin
            port_in = (t % 2 == 0) ? (v ^ 32'h1) : v;
            if (exp_drop < 255) exp_drop++;
            @(negedge clk);
        end
        wait_busy("sat_fall", 1'b0, 1000);
        chk("drop_sat", drop_count, exp_drop);
        check_frame("f_sat", v);
        quiet("sat_coalesced", 60);
        chk("sat_no_extra", rxq.size(), 0);
        chk("drop_sat_hold", drop_count, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/port_hex_uart.md
Name: port_hex_uart

Overview:
- Downstream consumer of the sc1_cpu `port_out` word (the 32-bit "count" output).
- Watches the word for changes and emits each new value over a UART TX line.
- Output format: 8 uppercase hex ASCII digits followed by CR LF.
- Gives on-board FPGA builds the same visibility the simulation monitor provides, with no host-side tooling beyond a terminal.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
- DATA_WIDTH, 32, width of the monitored word; must be a multiple of 4; digits per frame = DATA_WIDTH/4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- port_in  in  DATA_WIDTH  monitored word, connected to sc1_cpu port_out.
- uart_txd  out  1  UART serial output, 8N1, idle high.
- busy  out  1  high while a frame is being formatted or transmitted.
- drop_count  out  8  saturating count of port_in changes that arrived while busy.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is synchronous and active-high.
  - All state updates on the posedge of clk.
  - Reset values: uart_txd=1, busy=0, drop_count=0, last_value=0, prev_in=0, state=IDLE.
- Change detection:
  - prev_in <= port_in every cycle.
  - In IDLE, if port_in != last_value at edge N: snapshot <= port_in, last_value <= port_in, busy=1 from edge N, state -> LOAD.
  - A reset-time port_in of 0 produces no frame.
- Frame content:
  - DATA_WIDTH/4 characters, most-significant nibble first.
  - Nibble 0-9 -> 0x30-0x39; nibble A-F -> 0x41-0x46.
  - Then 0x0D, then 0x0A. Default frame = 10 characters.
- States:
  - IDLE: as above.
  - LOAD: select character[char_idx] and pulse start to uart_tx; go to SEND.
  - SEND: wait for uart_tx done. On done, if char_idx is the last index, go to IDLE; else char_idx+1 and go to LOAD.
- Start latency: uart_txd falls (start bit) at edge N+2.
- UART bit timing:
  - Each bit held exactly CLKS_PER_BIT cycles.
  - Bit order: start(0), d0..d7 (LSB first), stop(1).
  - The next character's start bit begins 1 cycle after the previous stop bit ends (LOAD bubble), so a character pitch is 10*CLKS_PER_BIT+1 cycles.
- Busy:
  - Drops at the edge after the last stop bit completes.
  - IDLE re-evaluates port_in vs last_value in that same cycle. Intermediate values are coalesced: only the latest value is printed after a frame.
- Drops:
  - While busy, each cycle with port_in != prev_in increments drop_count.
  - drop_count saturates at 255; it never wraps and is cleared only by reset.
- Reset mid-frame: reset takes effect within that cycle's edge. uart_txd returns high immediately, and the partial character is abandoned (receivers will see a framing error; acceptable).
- Simultaneous events: a change in the cycle busy falls is not counted as a drop; it is picked up by IDLE.

Decomposition:
- Shared include file `sc1_defs.vh`:
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A_MINUS_10=8'h37.
  - State encodings IDLE/LOAD/SEND.
- One sub-module, `uart_tx`:
  - Ports: clk, reset, start, data[7:0], txd, done.
  - Bit-period counter plus 4-bit bit index.
  - done is a one-cycle pulse at the end of the stop bit.
  - start is ignored while transmitting.
- Top level holds change detection, the nibble-to-ASCII mux, char_idx, and drop_count.

Test Plan:
1. CLKS_PER_BIT=4, reset, then port_in held 0 for 200 cycles -> uart_txd constant 1, busy=0, drop_count=0.
2. port_in 0 -> 32'h0000_00A5 at edge N:
   - busy high at N.
   - txd falls at N+2.
   - Decoded bytes "000000A5\r\n".
   - busy falls after 10*41-1 further cycles (last stop bit ends).
3. During frame 2, step port_in A5->A6->A7 at 3 different cycles:
   - drop_count=3.
   - Exactly one further frame "000000A7\r\n" follows; no frame for A6.
4. port_in=32'hDEAD_BEEF:
   - Decoded "DEADBEEF\r\n".
   - Bit-level check of the first char 'D' (0x44): txd = 0,0,0,1,0,0,0,1,0,1, each bit 4 cycles.
5. Assert reset during the 3rd character of a frame:
   - uart_txd=1 and busy=0 next cycle; drop_count=0; last_value=0.
   - A following change to 32'h1 yields a clean "00000001\r\n".
6. 300 toggles of port_in during one frame -> drop_count saturates at 255, not 44.
